argmax_classifier: RTL and testbench
====================================

// Module: argmax_classifier
// PURPOSE
//  Final stage of the digit classifier, directly downstream of the ten per-class neuron-sum units.
//  Captures each unit's 26-bit sum on its Output_Valid pulse.
//  Once all classes are held, runs a sequential signed compare, one class per cycle.
//  Emits the winning digit (0-9) and its score with a one-cycle valid pulse.
// PARAMETERS
//  NUM_CLASSES   10    number of neuron-sum lanes / output classes
//  DATA_W        26    width of each sum (signed two's complement fixed point)
//  IDX_W         4     width of class index; 2**IDX_W >= NUM_CLASSES
//  TIMEOUT_CYC   1023  max cycles first->last lane arrival (only with ARGMAX_TIMEOUT_EN)
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst           in   1                   asynchronous, active-low reset
//  Sum_In        in   NUM_CLASSES*DATA_W  lane k at [DATA_W*k +: DATA_W]
//  Sum_Valid     in   NUM_CLASSES         bit k = lane k Output_Valid pulse
//  Digit         out  IDX_W               index of max sum
//  Max_Value     out  DATA_W              value of max sum
//  Output_Valid  out  1                   one-cycle pulse, Digit/Max_Value valid
//  Busy          out  1                   high in COMPARE or DONE
//  Overrun       out  1                   sticky: Sum_Valid bit seen while Busy
//  Timeout       out  1                   one-cycle pulse on collect abort (0 if macro off)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, capture mask=0, all lane regs=0.
//   Digit=0, Max_Value=0, Output_Valid=0, Busy=0, Overrun=0, Timeout=0.
//  FSM states: IDLE, COLLECT, COMPARE, DONE.
//   IDLE: any Sum_Valid bit -> capture those lanes, set mask bits.
//    Mask full -> COMPARE, else -> COLLECT.
//   COLLECT: each valid lane captured on its edge.
//    A re-asserted lane overwrites its register (latest wins).
//    Mask full -> COMPARE.
//   COMPARE: first cycle loads best=lane0, best_idx=0, idx=1.
//    Each later edge: if lane[idx] > best (signed), best<=lane[idx], best_idx<=idx; idx++.
//    After lane NUM_CLASSES-1 is compared -> DONE.
//   DONE: one cycle with Output_Valid=1, then -> IDLE, mask cleared.
//  Latency: last lane captured at edge E.
//   Output_Valid is high for the cycle following edge E+NUM_CLASSES (10 cycles for default).
//  Digit/Max_Value registered at DONE entry; held until next DONE or reset.
//  Ties: strict '>' compare, so the lowest index wins.
//  Compare is full-width signed.
//   0x2000000 (most negative) loses to every other value.
//  Simultaneous arrival: all lanes valid in one cycle -> captured together, COMPARE next edge.
//  Sum_Valid while Busy: ignored (lane regs frozen); Overrun<=1, cleared only by reset.
//  Back-to-back frames: a Sum_Valid in the DONE cycle is dropped (sets Overrun).
//   Sum_Valid on the cycle after DONE is accepted in IDLE.
//  Reset mid-operation: immediate return to reset state; a pending result is discarded.
//   No Output_Valid pulse is issued.
// CONFIGURATION
//  ARGMAX_TIMEOUT_EN defined:
//   - A counter clears on IDLE->COLLECT and increments each cycle in COLLECT.
//   - Reaching TIMEOUT_CYC with the mask not full: -> IDLE, mask cleared, Timeout=1 for one cycle.
//   - No Output_Valid pulse is issued.
//  ARGMAX_TIMEOUT_EN undefined: no counter logic; Timeout tied 0; COLLECT waits indefinitely.
// TESTING
//  T1 sums lane k = k*100, all valid same cycle -> Digit=9, Max_Value=900, Output_Valid at E+10.
//  T2 lane3=-5, all other lanes=-20, staggered valids over 7 cycles -> Digit=3, Max_Value=-5 (0x3FFFFFB).
//  T3 lanes 2 and 6 both =0x0FFFFFF, rest 0 -> Digit=2 (tie, lowest index).
//  T4 pulse lane0 during COMPARE -> Overrun=1, result unchanged.
//   Next frame still correct; Overrun stays 1.
//  T5 rst low at COMPARE idx=5 -> all outputs 0 next cycle, no Output_Valid.
//   New frame afterwards gives correct Digit.
//  T6 (macro on, TIMEOUT_CYC=16) lanes 0-8 valid, lane 9 never -> Timeout pulse 16 cycles after first capture.
//   State IDLE; no Output_Valid.

Source files
------------

// File: rtl/argmax_classifier.sv
// Argmax stage of the digit classifier: collects ten per-class sums, then picks the largest one
// with a sequential signed compare. Optional collect timeout is enabled by defining ARGMAX_TIMEOUT_EN.
module argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 26,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLASSES*DATA_W-1:0] Sum_In,
    input  logic [NUM_CLASSES-1:0]        Sum_Valid,
    output logic [IDX_W-1:0]              Digit,
    output logic [DATA_W-1:0]             Max_Value,
    output logic                          Output_Valid,
    output logic                          Busy,
    output logic                          Overrun,
    output logic                          Timeout
);

    typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_t;

    localparam logic [NUM_CLASSES-1:0] FULL     = {NUM_CLASSES{1'b1}};
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    generate
        if ((2 ** IDX_W) < NUM_CLASSES || TIMEOUT_CYC < 2) begin : g_bad_params
            $error("argmax_classifier: IDX_W too narrow or TIMEOUT_CYC too small");
        end
    endgenerate

    state_t                   state, state_next;
    logic [NUM_CLASSES-1:0]   mask, mask_next;
    logic signed [DATA_W-1:0] lane [NUM_CLASSES];
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] cur_lane;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         idx;
    logic                     cur_gt;
    logic                     accept;

`ifdef ARGMAX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
`endif

    assign accept       = (state == IDLE) || (state == COLLECT);
    assign Busy         = (state == COMPARE) || (state == DONE);
    assign Output_Valid = (state == DONE);

    always_comb begin
        cur_lane = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_lane = lane[k];
            end
        end
    end

    // Strict greater-than keeps the earlier (lower) index on ties.
    assign cur_gt = cur_lane > best;

    always_comb begin
        state_next = state;
        mask_next  = mask;
`ifdef ARGMAX_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|Sum_Valid) begin
                    mask_next  = mask | Sum_Valid;
                    state_next = (mask_next == FULL) ? COMPARE : COLLECT;
                end
            end
            COLLECT: begin
                mask_next = mask | Sum_Valid;
                if (mask_next == FULL) begin
                    state_next = COMPARE;
                end
`ifdef ARGMAX_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_next  = IDLE;
                    mask_next   = '0;
                    timeout_hit = 1'b1;
                end
`endif
            end
            COMPARE: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                mask_next  = '0;
            end
            default: begin
                state_next = IDLE;
                mask_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            mask  <= '0;
        end else begin
            state <= state_next;
            mask  <= mask_next;
        end
    end

    // Lane registers only listen while collecting; a repeated lane simply overwrites.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                lane[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (Sum_Valid[k]) begin
                    lane[k] <= Sum_In[DATA_W*k +: DATA_W];
                end
            end
        end
    end

    // idx==0 marks the load cycle; the final compare writes the result as DONE is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            Digit     <= '0;
            Max_Value <= '0;
        end else if (state == COMPARE) begin
            if (idx == '0) begin
                best     <= lane[0];
                best_idx <= '0;
                idx      <= IDX_W'(1);
            end else begin
                if (cur_gt) begin
                    best     <= cur_lane;
                    best_idx <= idx;
                end
                if (idx == LAST_IDX) begin
                    Digit     <= cur_gt ? idx : best_idx;
                    Max_Value <= cur_gt ? cur_lane : best;
                    idx       <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Overrun <= 1'b0;
        end else if (Busy && (|Sum_Valid)) begin
            Overrun <= 1'b1;
        end
    end

`ifdef ARGMAX_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            Timeout <= 1'b0;
        end else begin
            Timeout <= timeout_hit;
            if (state == COLLECT) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed, table-driven bench for argmax_classifier with hand-written overrun, reset and
// incomplete-collect sequences; the timeout section follows ARGMAX_TIMEOUT_EN.
module tb_argmax_classifier;

    localparam int NC = 10;
    localparam int DW = 26;

    logic             clk;
    logic             rst;
    logic [NC*DW-1:0] Sum_In;
    logic [NC-1:0]    Sum_Valid;
    logic [3:0]       Digit;
    logic [DW-1:0]    Max_Value;
    logic             Output_Valid;
    logic             Busy;
    logic             Overrun;
    logic             Timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic [NC*DW-1:0] sums;
        int               stagger;
        logic [3:0]       exp_digit;
        logic [DW-1:0]    exp_value;
    } vec_t;

    vec_t vecs [6];

    argmax_classifier #(
        .NUM_CLASSES(NC),
        .DATA_W(DW),
        .IDX_W(4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Sum_In(Sum_In),
        .Sum_Valid(Sum_Valid),
        .Digit(Digit),
        .Max_Value(Max_Value),
        .Output_Valid(Output_Valid),
        .Busy(Busy),
        .Overrun(Overrun),
        .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NC*DW-1:0] mk(input int v0, input int v1, input int v2, input int v3,
                                            input int v4, input int v5, input int v6, input int v7,
                                            input int v8, input int v9);
        logic [NC*DW-1:0] r;
        int v [NC];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
        r = '0;
        for (int k = 0; k < NC; k++) begin
            r[DW*k +: DW] = DW'(v[k]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane k is pulsed in cycle (k % stagger); stagger 0 means all lanes in one cycle.
    task automatic applyStimulus(input logic [NC*DW-1:0] sums, input int stagger);
        logic [NC-1:0] pat;
        int last;
        Sum_In = sums;
        last = (stagger == 0) ? 0 : stagger - 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            pat = '0;
            for (int k = 0; k < NC; k++) begin
                if (stagger == 0 || (k % stagger) == c) pat[k] = 1'b1;
            end
            Sum_Valid = pat;
        end
        @(negedge clk);
        Sum_Valid = '0;
    endtask

    // Returns at the negedge inside the DONE cycle.
    task automatic checkResult(input string name, input logic [3:0] ed, input logic [DW-1:0] ev,
                               input int exp_lat);
        int cycles;
        cycles = 0;
        while (Output_Valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({name, " latency"}, cycles, exp_lat);
        checkOutput({name, " digit"}, {28'd0, Digit}, {28'd0, ed});
        checkOutput({name, " value"}, {6'd0, Max_Value}, {6'd0, ev});
        checkOutput({name, " busy_in_done"}, {31'd0, Busy}, 32'd1);
    endtask

    task automatic finishFrame(input string name);
        @(negedge clk);
        checkOutput({name, " valid_one_cycle"}, {31'd0, Output_Valid}, 32'd0);
        checkOutput({name, " busy_after"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ov_count;
        int to_count;
        int to_cycle;

        vecs[0] = '{"t1_ramp", mk(0, 100, 200, 300, 400, 500, 600, 700, 800, 900), 0, 4'd9, 26'd900};
        vecs[1] = '{"t2_negative", mk(-20, -20, -20, -5, -20, -20, -20, -20, -20, -20), 7, 4'd3, 26'h3FFFFFB};
        vecs[2] = '{"t3_tie", mk(0, 0, 'h0FFFFFF, 0, 0, 0, 'h0FFFFFF, 0, 0, 0), 3, 4'd2, 26'h0FFFFFF};
        vecs[3] = '{"most_negative", mk('h2000000, 'h2000000, 'h2000000, 'h2000000, 'h2000000,
                                        'h2000001, 'h2000000, 'h2000000, 'h2000000, 'h2000000),
                    2, 4'd5, 26'h2000001};
        vecs[4] = '{"all_equal", mk(7, 7, 7, 7, 7, 7, 7, 7, 7, 7), 5, 4'd0, 26'd7};
        vecs[5] = '{"signed_cmp", mk(0, 1, 2, 3, -1, 5, 6, 50, 8, 9), 0, 4'd7, 26'd50};

        rst = 1'b0;
        Sum_In = '0;
        Sum_Valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset digit", {28'd0, Digit}, 32'd0);
        checkOutput("reset value", {6'd0, Max_Value}, 32'd0);
        checkOutput("reset valid", {31'd0, Output_Valid}, 32'd0);
        checkOutput("reset busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset overrun", {31'd0, Overrun}, 32'd0);
        checkOutput("reset timeout", {31'd0, Timeout}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].sums, vecs[i].stagger);
            checkResult(vecs[i].name, vecs[i].exp_digit, vecs[i].exp_value, 10);
            finishFrame(vecs[i].name);
        end
        checkOutput("no overrun after clean frames", {31'd0, Overrun}, 32'd0);

        // Lane 9 arrives twice: the second (smaller) value must be the one compared.
        @(negedge clk);
        Sum_In = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1000);
        Sum_Valid = 10'h200;
        @(negedge clk);
        Sum_In = mk(0, 10, 0, 0, 0, 0, 0, 0, 0, 5);
        Sum_Valid = 10'h3FF;
        @(negedge clk);
        Sum_Valid = '0;
        checkResult("latest_wins", 4'd1, 26'd10, 10);
        finishFrame("latest_wins");

        // Lanes 0 and 9 pulsed during COMPARE must be ignored.
        applyStimulus(mk(0, 100, 200, 300, 400, 500, 600, 700, 800, 900), 0);
        @(negedge clk);
        Sum_In = mk(5000, 0, 0, 0, 0, 0, 0, 0, 0, 6000);
        Sum_Valid = 10'h201;
        @(negedge clk);
        Sum_Valid = '0;
        checkResult("overrun_frame", 4'd9, 26'd900, 8);
        checkOutput("overrun set", {31'd0, Overrun}, 32'd1);

        // Lane 9 offered in the DONE cycle is dropped; lanes 0-8 next cycle must not complete the frame.
        Sum_In = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1FFFFFF);
        Sum_Valid = 10'h200;
        @(negedge clk);
        Sum_In = mk(0, 0, 0, 77, 0, 0, 0, 0, 0, 0);
        Sum_Valid = 10'h1FF;
        @(negedge clk);
        Sum_Valid = '0;
        repeat (3) @(negedge clk);
        Sum_In = mk(0, 0, 0, 77, 0, 0, 0, 0, 0, 2);
        Sum_Valid = 10'h200;
        @(negedge clk);
        Sum_Valid = '0;
        checkResult("done_drop", 4'd3, 26'd77, 10);
        finishFrame("done_drop");
        checkOutput("overrun sticky", {31'd0, Overrun}, 32'd1);

        // Reset while COMPARE is at idx 5.
        applyStimulus(mk(900, 800, 700, 600, 500, 400, 300, 200, 100, 0), 0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset digit", {28'd0, Digit}, 32'd0);
        checkOutput("midreset value", {6'd0, Max_Value}, 32'd0);
        checkOutput("midreset busy", {31'd0, Busy}, 32'd0);
        checkOutput("midreset overrun", {31'd0, Overrun}, 32'd0);
        rst = 1'b1;
        ov_count = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (Output_Valid === 1'b1) ov_count++;
        end
        checkOutput("midreset no valid", ov_count, 0);
        applyStimulus(mk(1, 2, 3, 4, 1234, 6, 7, 8, 9, 10), 0);
        checkResult("after_reset", 4'd4, 26'd1234, 10);
        finishFrame("after_reset");

        // Incomplete collect: lanes 0-8 only.
        @(negedge clk);
        Sum_In = mk(0, 10, 20, 30, 40, 50, 60, 70, 80, 3);
        Sum_Valid = 10'h1FF;
        @(negedge clk);
        Sum_Valid = '0;
        ov_count = 0;
        to_count = 0;
        to_cycle = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (Output_Valid === 1'b1) ov_count++;
            if (Timeout === 1'b1) begin
                to_count++;
                if (to_cycle < 0) to_cycle = n;
            end
        end
        checkOutput("incomplete no valid", ov_count, 0);
        checkOutput("incomplete busy", {31'd0, Busy}, 32'd0);
`ifdef ARGMAX_TIMEOUT_EN
        checkOutput("timeout pulses", to_count, 1);
        checkOutput("timeout cycle", to_cycle, 16);
        applyStimulus(mk(0, 10, 20, 30, 40, 50, 60, 70, 80, 3), 0);
        checkResult("after_timeout", 4'd8, 26'd80, 10);
        finishFrame("after_timeout");
`else
        checkOutput("timeout stays low", to_count, 0);
        Sum_Valid = 10'h200;
        @(negedge clk);
        Sum_Valid = '0;
        checkResult("late_lane9", 4'd8, 26'd80, 10);
        finishFrame("late_lane9");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
